mul_norm_shift: RTL and testbench
=================================

Name: mul_norm_shift

Overview:
- Pipelined left-normalizer for the multiplier datapath. Consumes a raw product mantissa, its leading-zero count and a biased exponent.
- Shifts the mantissa so its MSB is set, decrements the exponent by the applied shift, and clamps at the subnormal boundary.
- Sits directly after leading-zero detection, ahead of rounding.
- Two-stage, valid/ready backpressured pipeline; throughput 1 per cycle.

Parameters:
- WIDTH, 24, mantissa width in bits.
- LZ_WIDTH, $clog2(WIDTH)+1, width of the leading-zero count input.
- EXP_WIDTH, 10, biased exponent width (unsigned).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_mant  input  WIDTH  unnormalized mantissa.
- in_lz  input  LZ_WIDTH  leading-zero count of in_mant; values >= WIDTH mean all-zero.
- in_exp  input  EXP_WIDTH  biased exponent before normalization.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts the beat.
- out_mant  output  WIDTH  normalized mantissa.
- out_exp  output  EXP_WIDTH  adjusted exponent.
- out_zero  output  1  mantissa was all-zero.
- out_denorm  output  1  shift was clamped; result is subnormal (out_exp = 0).

Behaviour:
- Reset: asynchronous, active-high. Reset clears out_valid and the internal stage-1 valid. out_mant, out_exp, out_zero and out_denorm reset to 0. in_ready = 1 after reset.
- Handshake:
  - Transfer occurs when valid && ready.
  - in_ready = !s1_valid || s1_advance.
  - s1_advance = !out_valid || out_ready.
  - in_ready must not depend on in_valid.
  - out_valid is held, and out_* held stable, until out_ready = 1.
- Latency: 2 cycles from input accept to out_valid with no backpressure. Full rate with out_ready tied high.
- Stage 1 (registered on accept):
  - zero = (in_mant == 0) || (in_lz >= WIDTH).
  - If zero: shift = 0, exp_next = 0, denorm = 0.
  - Else if in_exp == 0: shift = 0, exp_next = 0, denorm = 1.
  - Else if in_lz <= in_exp-1: shift = in_lz, exp_next = in_exp - in_lz, denorm = 0.
  - Else: shift = in_exp-1, exp_next = 0, denorm = 1.
  - Mantissa registered unshifted.
- Stage 2 (registered when s1_advance && s1_valid): out_mant = s1_mant << shift, zero-filled from the LSB.
  - Barrel shifter built as log2 stages; no combinational path from in_* to out_*.
- Arithmetic: exponent subtraction is unsigned in EXP_WIDTH bits. The clamp guarantees no wrap.
- Trust: in_lz is trusted. No cross-check against in_mant except the all-zero detection.
- Bubbles:
  - s1 empty while out is stalled: stage 1 may fill. A third beat is refused (in_ready = 0).
  - Simultaneous out accept and in accept with both stages full: both stages shift forward in the same cycle, with no bubble.
- Reset mid-operation drops all in-flight beats; no partial output.

Test Plan:
1. in_mant=24'h00_1234 (lz=11), in_exp=127, out_ready=1 -> after 2 cycles out_mant=24'h91_A000, out_exp=116, out_zero=0, out_denorm=0.
2. in_mant=24'h00_0001 (lz=23), in_exp=5 -> shift clamped to 4: out_mant=24'h00_0010, out_exp=0, out_denorm=1.
3. in_mant=0, in_lz=24, in_exp=200 -> out_mant=0, out_exp=0, out_zero=1, out_denorm=0.
4. Stream 8 back-to-back beats with out_ready=1 -> 8 consecutive out_valid cycles, order preserved, in_ready constantly 1.
5. Hold out_ready=0 for 5 cycles during a stream -> in_ready=0 after 2 beats are accepted, out_* stable. On release, output resumes with no loss or duplication.
6. Assert rst while both stages are valid -> out_valid=0 and outputs=0 immediately (async); the next accepted beat emerges 2 cycles later.

Source files
------------

// File: rtl/mul_norm_shift.sv
// Two-stage left normalizer: shift mantissa MSB-up, debit exponent,
// clamp at the subnormal boundary. Valid/ready on both sides.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   in_valid/in_ready             upstream handshake
//   in_mant/in_lz/in_exp          raw mantissa, its lz count, biased exp
//   out_valid/out_ready           downstream handshake
//   out_mant/out_exp              normalized mantissa, adjusted exponent
//   out_zero/out_denorm           all-zero flag, clamped (subnormal) flag
module mul_norm_shift #(
    parameter int WIDTH     = 24,
    parameter int LZ_WIDTH  = $clog2(WIDTH) + 1,
    parameter int EXP_WIDTH = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_mant,
    input  logic [LZ_WIDTH-1:0]  in_lz,
    input  logic [EXP_WIDTH-1:0] in_exp,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_mant,
    output logic [EXP_WIDTH-1:0] out_exp,
    output logic                 out_zero,
    output logic                 out_denorm
);

    // A non-zero result never shifts by WIDTH or more, so this is enough.
    localparam int SH_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [LZ_WIDTH-1:0] LZ_ALLZ = LZ_WIDTH'(WIDTH);

    logic                 w_s1_adv;
    logic                 w_in_fire;
    logic                 w_zero;
    logic                 w_denorm;
    logic [SH_W-1:0]      w_shift;
    logic [EXP_WIDTH-1:0] w_exp_nx;
    logic [EXP_WIDTH-1:0] w_exp_m1;
    logic [EXP_WIDTH-1:0] w_lz_ext;

    logic                 r_s1_valid;
    logic [WIDTH-1:0]     r_s1_mant;
    logic [SH_W-1:0]      r_s1_shift;
    logic [EXP_WIDTH-1:0] r_s1_exp;
    logic                 r_s1_zero;
    logic                 r_s1_denorm;

    logic                 r_out_valid;
    logic [WIDTH-1:0]     r_out_mant;
    logic [EXP_WIDTH-1:0] r_out_exp;
    logic                 r_out_zero;
    logic                 r_out_denorm;

    assign w_s1_adv  = !r_out_valid || out_ready;
    assign in_ready  = !r_s1_valid || w_s1_adv;
    assign w_in_fire = in_valid && in_ready;

    assign w_exp_m1 = in_exp - EXP_WIDTH'(1);
    assign w_lz_ext = EXP_WIDTH'(in_lz);

    always_comb begin
        w_zero   = (in_mant == '0) || (in_lz >= LZ_ALLZ);
        w_shift  = '0;
        w_exp_nx = '0;
        w_denorm = 1'b0;
        if (w_zero) begin
            w_denorm = 1'b0;
        end else if (in_exp == '0) begin
            w_denorm = 1'b1;
        end else if (w_lz_ext <= w_exp_m1) begin
            w_shift  = SH_W'(in_lz);
            w_exp_nx = in_exp - w_lz_ext;
        end else begin
            // Only reachable with in_exp-1 < in_lz < WIDTH.
            w_shift  = SH_W'(w_exp_m1);
            w_denorm = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_mant   <= '0;
            r_s1_shift  <= '0;
            r_s1_exp    <= '0;
            r_s1_zero   <= 1'b0;
            r_s1_denorm <= 1'b0;
        end else if (w_in_fire) begin
            r_s1_valid  <= 1'b1;
            r_s1_mant   <= in_mant;
            r_s1_shift  <= w_shift;
            r_s1_exp    <= w_exp_nx;
            r_s1_zero   <= w_zero;
            r_s1_denorm <= w_denorm;
        end else if (w_s1_adv) begin
            r_s1_valid  <= 1'b0;
        end
    end

    // Logarithmic barrel shifter fed only from stage-1 registers.
    logic [WIDTH-1:0] w_stg [0:SH_W];

    assign w_stg[0] = r_s1_mant;

    for (genvar k = 0; k < SH_W; k++) begin : g_bsh
        assign w_stg[k+1] = r_s1_shift[k] ? (w_stg[k] << (2 ** k))
                                          : w_stg[k];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_mant   <= '0;
            r_out_exp    <= '0;
            r_out_zero   <= 1'b0;
            r_out_denorm <= 1'b0;
        end else if (w_s1_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_mant   <= w_stg[SH_W];
                r_out_exp    <= r_s1_exp;
                r_out_zero   <= r_s1_zero;
                r_out_denorm <= r_s1_denorm;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_mant   = r_out_mant;
    assign out_exp    = r_out_exp;
    assign out_zero   = r_out_zero;
    assign out_denorm = r_out_denorm;

endmodule

// File: tb/tb_mul_norm_shift.sv
// Bench for mul_norm_shift: directed vectors, streaming, stalls,
// random traffic and async reset, against a queue-based model.
module tb_mul_norm_shift;

    localparam int W   = 24;
    localparam int LZW = 6;
    localparam int EW  = 10;

    typedef struct packed {
        logic [W-1:0]  mant;
        logic [EW-1:0] exp;
        logic          zero;
        logic          denorm;
    } res_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_mant;
    logic [LZW-1:0] in_lz;
    logic [EW-1:0]  in_exp;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_mant;
    logic [EW-1:0]  out_exp;
    logic           out_zero;
    logic           out_denorm;

    int   n_cmp = 0;
    int   n_bad = 0;
    res_t q[$];

    mul_norm_shift dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mant   (in_mant),
        .in_lz     (in_lz),
        .in_exp    (in_exp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mant  (out_mant),
        .out_exp   (out_exp),
        .out_zero  (out_zero),
        .out_denorm(out_denorm)
    );

    always #5 clk = ~clk;

    function automatic res_t model(logic [W-1:0] m, int lz, int e);
        res_t r;
        r = '0;
        if (m == 0 || lz >= W) begin
            r.mant = m;
            r.zero = 1'b1;
        end else if (e == 0) begin
            r.mant   = m;
            r.denorm = 1'b1;
        end else if (lz <= e - 1) begin
            r.mant = m << lz;
            r.exp  = EW'(e - lz);
        end else begin
            r.mant   = m << (e - 1);
            r.denorm = 1'b1;
        end
        return r;
    endfunction

    function automatic int count_lz(logic [W-1:0] m);
        for (int i = W - 1; i >= 0; i--)
            if (m[i]) return W - 1 - i;
        return W;
    endfunction

    // Drive one cycle; report whether the output transfers at the coming
    // edge and, if so, what the model expects for it.
    task automatic drive(input logic v, input logic [W-1:0] m,
                         input logic [LZW-1:0] lz, input logic [EW-1:0] e,
                         input logic ordy, output bit fire,
                         output bit has, output res_t ex);
        @(negedge clk);
        in_valid  = v;
        in_mant   = m;
        in_lz     = lz;
        in_exp    = e;
        out_ready = ordy;
        #1;
        fire = out_valid && out_ready;
        has  = 1'b0;
        ex   = '0;
        if (fire && q.size() > 0) begin
            ex  = q.pop_front();
            has = 1'b1;
        end
        if (in_valid && in_ready)
            q.push_back(model(m, int'(lz), int'(e)));
    endtask

    task automatic rand_beat(output logic [W-1:0] m,
                             output logic [LZW-1:0] lz,
                             output logic [EW-1:0] e);
        int k;
        k = $urandom_range(0, W);
        if (k == W) m = '0;
        else m = (W'(1) << (W - 1 - k)) |
                 (W'($urandom) & ((W'(1) << (W - 1 - k)) - W'(1)));
        lz = LZW'(count_lz(m));
        if ($urandom_range(0, 15) == 0)
            lz = LZW'($urandom_range(W, 63));
        if ($urandom_range(0, 2) == 0) e = EW'($urandom_range(0, 30));
        else e = EW'($urandom_range(0, 1023));
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({out_valid, out_mant, out_exp, out_zero, out_denorm} !== '0) begin
            n_bad++;
            $display("FAIL reset_out: got v=%b m=%h e=%0d z=%b d=%b want all 0",
                     out_valid, out_mant, out_exp, out_zero, out_denorm);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0]   vm [3] = '{24'h001234, 24'h000001, 24'h000000};
        logic [LZW-1:0] vl [3] = '{6'd11, 6'd23, 6'd24};
        logic [EW-1:0]  ve [3] = '{10'd127, 10'd5, 10'd200};
        res_t           vw [3] = '{{24'h91A000, 10'd116, 1'b0, 1'b0},
                                   {24'h000010, 10'd0, 1'b0, 1'b1},
                                   {24'h000000, 10'd0, 1'b1, 1'b0}};
        bit   fire, has;
        res_t ex;
        int   lat;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, vm[i], vl[i], ve[i], 1'b1, fire, has, ex);
            lat  = 0;
            fire = 1'b0;
            while (!fire && lat < 8) begin
                drive(1'b0, '0, '0, '0, 1'b1, fire, has, ex);
                lat++;
            end
            n_cmp++;
            if (lat !== 2) begin
                n_bad++;
                $display("FAIL dir%0d_latency: got %0d want 2", i, lat);
            end
            n_cmp++;
            if ({out_mant, out_exp, out_zero, out_denorm} !== vw[i]) begin
                n_bad++;
                $display("FAIL dir%0d_value: got m=%h e=%0d z=%b d=%b want m=%h e=%0d z=%b d=%b",
                         i, out_mant, out_exp, out_zero, out_denorm,
                         vw[i].mant, vw[i].exp, vw[i].zero, vw[i].denorm);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit             fire, has;
        res_t           ex;
        logic [W-1:0]   m;
        logic [LZW-1:0] lz;
        logic [EW-1:0]  e;
        int             nout, first, last, cyc;
        nout  = 0;
        first = -1;
        last  = -1;
        cyc   = 0;
        while ((nout < 8) && (cyc < 20)) begin
            if (cyc < 8) rand_beat(m, lz, e);
            drive(cyc < 8, m, lz, e, 1'b1, fire, has, ex);
            if (cyc < 8) begin
                n_cmp++;
                if (in_ready !== 1'b1) begin
                    n_bad++;
                    $display("FAIL b2b_in_ready: cycle %0d got %b want 1",
                             cyc, in_ready);
                end
            end
            if (fire) begin
                if (first < 0) first = cyc;
                last = cyc;
                nout++;
                n_cmp++;
                if (!has || {out_mant, out_exp, out_zero, out_denorm} !== ex) begin
                    n_bad++;
                    $display("FAIL b2b_value: got %h want %h (model %0d)",
                             {out_mant, out_exp, out_zero, out_denorm}, ex, has);
                end
            end
            cyc++;
        end
        n_cmp++;
        if (nout != 8 || first != 2 || last != 9) begin
            n_bad++;
            $display("FAIL b2b_timing: got n=%0d first=%0d last=%0d want 8/2/9",
                     nout, first, last);
        end
    endtask

    task automatic test_backpressure();
        bit             fire, has;
        res_t           ex, snap;
        logic [W-1:0]   m;
        logic [LZW-1:0] lz;
        logic [EW-1:0]  e;
        int             acc, cyc;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            rand_beat(m, lz, e);
            drive(1'b1, m, lz, e, 1'b0, fire, has, ex);
            if (in_ready) acc++;
            if (i >= 2) begin
                n_cmp++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                    n_bad++;
                    $display("FAIL bp_full: cycle %0d got in_ready=%b out_valid=%b want 0/1",
                             i, in_ready, out_valid);
                end
            end
            if (i == 2) snap = {out_mant, out_exp, out_zero, out_denorm};
            if (i > 2) begin
                n_cmp++;
                if ({out_mant, out_exp, out_zero, out_denorm} !== snap) begin
                    n_bad++;
                    $display("FAIL bp_stable: got %h want %h",
                             {out_mant, out_exp, out_zero, out_denorm}, snap);
                end
            end
        end
        n_cmp++;
        if (acc != 2) begin
            n_bad++;
            $display("FAIL bp_accepted: got %0d want 2", acc);
        end
        cyc = 0;
        while ((cyc < 4 || q.size() > 0) && cyc < 20) begin
            if (cyc < 4) rand_beat(m, lz, e);
            drive(cyc < 4, m, lz, e, 1'b1, fire, has, ex);
            if (fire) begin
                n_cmp++;
                if (!has || {out_mant, out_exp, out_zero, out_denorm} !== ex) begin
                    n_bad++;
                    $display("FAIL bp_resume: got %h want %h (model %0d)",
                             {out_mant, out_exp, out_zero, out_denorm}, ex, has);
                end
            end
            cyc++;
        end
        drive(1'b0, '0, '0, '0, 1'b1, fire, has, ex);
        n_cmp++;
        if (q.size() != 0 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_drain: got pending=%0d out_valid=%b want 0/0",
                     q.size(), out_valid);
        end
    endtask

    task automatic test_random();
        bit             fire, has;
        res_t           ex;
        logic [W-1:0]   m;
        logic [LZW-1:0] lz;
        logic [EW-1:0]  e;
        int             cyc;
        cyc = 0;
        while ((cyc < 400 || q.size() > 0) && cyc < 440) begin
            rand_beat(m, lz, e);
            drive((cyc < 400) && ($urandom_range(0, 9) < 7), m, lz, e,
                  (cyc >= 400) || ($urandom_range(0, 9) < 7),
                  fire, has, ex);
            if (fire) begin
                n_cmp++;
                if (!has || {out_mant, out_exp, out_zero, out_denorm} !== ex) begin
                    n_bad++;
                    $display("FAIL rand_value: cycle %0d got %h want %h (model %0d)",
                             cyc, {out_mant, out_exp, out_zero, out_denorm}, ex, has);
                end
            end
            cyc++;
        end
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL rand_drain: got %0d pending want 0", q.size());
        end
    endtask

    task automatic test_reset_midflight();
        bit   fire, has;
        res_t ex, want;
        int   lat;
        drive(1'b1, 24'h00F000, 6'd8, 10'd50, 1'b0, fire, has, ex);
        drive(1'b1, 24'h0000FF, 6'd16, 10'd3, 1'b0, fire, has, ex);
        drive(1'b0, '0, '0, '0, 1'b0, fire, has, ex);
        n_cmp++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_prefill: got out_valid=%b in_ready=%b want 1/0",
                     out_valid, in_ready);
        end
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, out_mant, out_exp, out_zero, out_denorm} !== '0 ||
            in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_async: got v=%b m=%h e=%0d z=%b d=%b rdy=%b want 0s, rdy=1",
                     out_valid, out_mant, out_exp, out_zero, out_denorm, in_ready);
        end
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        want = model(24'h000ABC, 12, 400);
        drive(1'b1, 24'h000ABC, 6'd12, 10'd400, 1'b1, fire, has, ex);
        lat  = 0;
        fire = 1'b0;
        while (!fire && lat < 8) begin
            drive(1'b0, '0, '0, '0, 1'b1, fire, has, ex);
            lat++;
        end
        n_cmp++;
        if (lat != 2 || {out_mant, out_exp, out_zero, out_denorm} !== want) begin
            n_bad++;
            $display("FAIL rst_recover: got lat=%0d val=%h want lat=2 val=%h",
                     lat, {out_mant, out_exp, out_zero, out_denorm}, want);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_mant   = '0;
        in_lz     = '0;
        in_exp    = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
